// File: rtl/borrow_bypass_subtractor.sv
// ============================================================================
// Module      : borrow_bypass_subtractor
// Description : Multi-cycle A - B - Bin subtractor, one BLOCK-bit slice per
//               cycle, with a borrow-bypass mux on propagate slices.
//               Optional macro SKIP_COUNT_EN adds the skip_count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module borrow_bypass_subtractor #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             Bout,
    output logic             zero,
    output logic             ovf
`ifdef SKIP_COUNT_EN
    ,
    output logic [2:0]       skip_count
`endif
);

    localparam int c_NSLICE = WIDTH / BLOCK;
    localparam int c_KW     = (c_NSLICE > 1) ? $clog2(c_NSLICE) : 1;
    localparam logic [c_KW-1:0] c_LAST_K = c_KW'(c_NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic [c_KW-1:0]   k_q, k_d;
    logic              borrow_q, borrow_d;
    logic              bout_q, bout_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
`ifdef SKIP_COUNT_EN
    logic [2:0]        skip_cnt_q, skip_cnt_d;
    logic [2:0]        skip_q, skip_d;
`endif

    logic [BLOCK-1:0]  w_sa, w_sb, w_sd;
    logic              w_bchain;
    logic              w_ripple;
    logic              w_prop;
    logic              w_sbo;
    logic [WIDTH-1:0]  w_acc_next;

    // Select the active slice k of the captured operands
    always_comb begin
        w_sa = '0;
        w_sb = '0;
        for (int s = 0; s < c_NSLICE; s++) begin
            if (k_q == c_KW'(s)) begin
                w_sa = a_q[s*BLOCK +: BLOCK];
                w_sb = b_q[s*BLOCK +: BLOCK];
            end
        end
    end

    always_comb begin
        w_sd     = '0;
        w_bchain = borrow_q;
        for (int i = 0; i < BLOCK; i++) begin
            w_sd[i]  = w_sa[i] ^ w_sb[i] ^ w_bchain;
            w_bchain = (~w_sa[i] & w_sb[i]) | (~(w_sa[i] ^ w_sb[i]) & w_bchain);
        end
        w_ripple = w_bchain;
        // Equal bits everywhere: the borrow passes straight through the slice
        w_prop   = (w_sa == w_sb);
        w_sbo    = w_prop ? borrow_q : w_ripple;
    end

    always_comb begin
        for (int s = 0; s < c_NSLICE; s++) begin
            w_acc_next[s*BLOCK +: BLOCK] = (k_q == c_KW'(s)) ? w_sd
                                                            : acc_q[s*BLOCK +: BLOCK];
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        diff_d     = diff_q;
        k_d        = k_q;
        borrow_d   = borrow_q;
        bout_d     = bout_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
`ifdef SKIP_COUNT_EN
        skip_cnt_d = skip_cnt_q;
        skip_d     = skip_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = A;
                    b_d        = B;
                    borrow_d   = Bin;
                    acc_d      = '0;
                    k_d        = '0;
`ifdef SKIP_COUNT_EN
                    skip_cnt_d = '0;
`endif
                    state_d    = RUN;
                end
            end
            RUN: begin
                acc_d    = w_acc_next;
                borrow_d = w_sbo;
                k_d      = k_q + c_KW'(1);
`ifdef SKIP_COUNT_EN
                skip_cnt_d = skip_cnt_q + {2'b00, w_prop};
`endif
                if (k_q == c_LAST_K) begin
                    // Results land in their own registers so they hold past the handshake
                    diff_d  = w_acc_next;
                    bout_d  = w_sbo;
                    zero_d  = (w_acc_next == '0);
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (w_acc_next[WIDTH-1] != a_q[WIDTH-1]);
`ifdef SKIP_COUNT_EN
                    skip_d  = skip_cnt_q + {2'b00, w_prop};
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            diff_q     <= '0;
            k_q        <= '0;
            borrow_q   <= 1'b0;
            bout_q     <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef SKIP_COUNT_EN
            skip_cnt_q <= '0;
            skip_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            diff_q     <= diff_d;
            k_q        <= k_d;
            borrow_q   <= borrow_d;
            bout_q     <= bout_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
`ifdef SKIP_COUNT_EN
            skip_cnt_q <= skip_cnt_d;
            skip_q     <= skip_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign Bout      = bout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
`ifdef SKIP_COUNT_EN
    assign skip_count = skip_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_borrow_bypass_subtractor.sv
// ============================================================================
// Module      : tb_borrow_bypass_subtractor
// Description : Self-checking bench for borrow_bypass_subtractor (32/8 build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_borrow_bypass_subtractor;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        Bout;
    logic        zero;
    logic        ovf;
`ifdef SKIP_COUNT_EN
    logic [2:0]  skip_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int total_bypass = 0;

    borrow_bypass_subtractor #(.WIDTH(32), .BLOCK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .Bout      (Bout),
        .zero      (zero),
        .ovf       (ovf)
`ifdef SKIP_COUNT_EN
        ,
        .skip_count(skip_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain 33-bit arithmetic and byte-wise equality count
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic bin,
                         output logic [31:0] d, output logic bo, output logic z,
                         output logic o, output int sk);
        logic [32:0] t;
        t  = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        d  = t[31:0];
        bo = t[32];
        z  = (d == 32'd0);
        o  = (a[31] != b[31]) && (d[31] != a[31]);
        sk = 0;
        for (int s = 0; s < 4; s++) if (a[s*8 +: 8] == b[s*8 +: 8]) sk++;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                            output int acc_cyc);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL start_op_timeout in_ready=%b required=1", in_ready);
        end
        A = a; B = b; Bin = bin; in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Bin = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        n_checks++;
        if (diff !== 32'd0 || Bout !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_results diff=%h Bout=%b zero=%b ovf=%b required all 0", diff, Bout, zero, ovf);
        end
`ifdef SKIP_COUNT_EN
        n_checks++;
        if (skip_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_skip skip_count=%0d required=0", skip_count);
        end
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic        vbin [5];
        logic [31:0] ed [5];
        logic        ebo [5];
        logic        ez [5];
        logic        eo [5];
        int          esk [5];
        int          lat, ac;
        va   = '{32'h00000005, 32'h00000000, 32'h12345678, 32'h12345678, 32'h80000000};
        vb   = '{32'h00000003, 32'h00000001, 32'h12345678, 32'h12345678, 32'h00000001};
        vbin = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ed   = '{32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h7FFFFFFF};
        ebo  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ez   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        eo   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        esk  = '{3, 3, 4, 4, 2};
        for (int i = 0; i < 5; i++) begin
            start_op(va[i], vb[i], vbin[i], ac);
            wait_done(lat);
            n_checks++;
            if (lat !== 4) begin
                n_fail++;
                $display("FAIL directed%0d_latency got=%0d required=4", i, lat);
            end
            n_checks++;
            if (diff !== ed[i] || Bout !== ebo[i] || zero !== ez[i] || ovf !== eo[i]) begin
                n_fail++;
                $display("FAIL directed%0d_result diff=%h Bout=%b zero=%b ovf=%b required %h/%b/%b/%b",
                         i, diff, Bout, zero, ovf, ed[i], ebo[i], ez[i], eo[i]);
            end
`ifdef SKIP_COUNT_EN
            n_checks++;
            if (skip_count !== 3'(esk[i])) begin
                n_fail++;
                $display("FAIL directed%0d_skip got=%0d required=%0d", i, skip_count, esk[i]);
            end
`else
            if (esk[i] < 0) $display("note: unexpected table entry");
`endif
            handshake();
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, d;
        logic        bin, bo, z, o;
        int          sk, lat, ac, hold;
        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            b = $urandom;
            for (int s = 0; s < 4; s++) if ($urandom_range(0, 1) == 1) b[s*8 +: 8] = a[s*8 +: 8];
            bin = 1'($urandom_range(0, 1));
            model(a, b, bin, d, bo, z, o, sk);
            total_bypass += sk;
            start_op(a, b, bin, ac);
            wait_done(lat);
            hold = $urandom_range(0, 2);
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            n_checks++;
            if (lat !== 4 || out_valid !== 1'b1 || diff !== d || Bout !== bo ||
                zero !== z || ovf !== o) begin
                n_fail++;
                $display("FAIL random%0d A=%h B=%h Bin=%b lat=%0d ov=%b diff=%h Bout=%b zero=%b ovf=%b required lat=4 ov=1 %h/%b/%b/%b",
                         n, a, b, bin, lat, out_valid, diff, Bout, zero, ovf, d, bo, z, o);
            end
`ifdef SKIP_COUNT_EN
            n_checks++;
            if (skip_count !== 3'(sk)) begin
                n_fail++;
                $display("FAIL random%0d_skip got=%0d required=%0d", n, skip_count, sk);
            end
`endif
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic        bo, z, o;
        int          sk, lat, ac;
        model(32'hA5A50F0F, 32'h5A5A0F10, 1'b1, d, bo, z, o, sk);
        start_op(32'hA5A50F0F, 32'h5A5A0F10, 1'b1, ac);
        wait_done(lat);
        in_valid = 1'b1; A = 32'h11111111; B = 32'h22222222; Bin = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== d || Bout !== bo || ovf !== o) begin
                n_fail++;
                $display("FAIL backpressure_hold%0d ov=%b ir=%b diff=%h Bout=%b ovf=%b required 1/0/%h/%b/%b",
                         c, out_valid, in_ready, diff, Bout, ovf, d, bo, o);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release ov=%b ir=%b required 0/1", out_valid, in_ready);
        end
        n_checks++;
        if (diff !== d || Bout !== bo) begin
            n_fail++;
            $display("FAIL result_persist diff=%h Bout=%b required %h/%b", diff, Bout, d, bo);
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] a, b, d;
        logic        bo, z, o, seen;
        int          sk, lat, ac;
        start_op(32'hDEADBEEF, 32'h01234567, 1'b0, ac);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 32'd0) begin
            n_fail++;
            $display("FAIL midrun_reset ir=%b ov=%b diff=%h required 1/0/0", in_ready, out_valid, diff);
        end
        #2;
        rst  = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_abort out_valid_seen=%b required=0", seen);
        end
        a = $urandom; b = $urandom;
        model(a, b, 1'b1, d, bo, z, o, sk);
        start_op(a, b, 1'b1, ac);
        wait_done(lat);
        n_checks++;
        if (lat !== 4 || diff !== d || Bout !== bo || ovf !== o) begin
            n_fail++;
            $display("FAIL after_reset_op lat=%0d diff=%h Bout=%b ovf=%b required 4/%h/%b/%b",
                     lat, diff, Bout, ovf, d, bo, o);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, d;
        logic        bo, z, o;
        int          sk, lat, ac, prev;
        prev = -1;
        for (int n = 0; n < 3; n++) begin
            a = $urandom; b = $urandom;
            model(a, b, 1'b0, d, bo, z, o, sk);
            start_op(a, b, 1'b0, ac);
            if (prev >= 0) begin
                n_checks++;
                if (ac - prev !== 6) begin
                    n_fail++;
                    $display("FAIL b2b_period%0d got=%0d required=6", n, ac - prev);
                end
            end
            prev = ac;
            wait_done(lat);
            n_checks++;
            if (diff !== d || Bout !== bo || zero !== z || ovf !== o) begin
                n_fail++;
                $display("FAIL b2b%0d diff=%h Bout=%b zero=%b ovf=%b required %h/%b/%b/%b",
                         n, diff, Bout, zero, ovf, d, bo, z, o);
            end
            handshake();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        $display("random bypassed slices exercised: %0d", total_bypass);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/borrow_bypass_subtractor.md
BORROW_BYPASS_SUBTRACTOR -- requirements
Module: borrow_bypass_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; must be an integer multiple of BLOCK.
REQ-002 SHALL have parameter BLOCK, default 8: slice width processed per RUN cycle.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operands present.
REQ-006 SHALL have port in_ready, output, 1: block can accept operands.
REQ-007 SHALL have port A, input, WIDTH: minuend.
REQ-008 SHALL have port B, input, WIDTH: subtrahend.
REQ-009 SHALL have port Bin, input, 1: borrow-in.
REQ-010 SHALL have port out_valid, output, 1: result available.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-012 SHALL have port diff, output, WIDTH: A - B - Bin, modulo 2^WIDTH.
REQ-013 SHALL have port Bout, output, 1: borrow-out of the MSB slice.
REQ-014 SHALL have port zero, output, 1: diff == 0.
REQ-015 SHALL have port ovf, output, 1: two's-complement overflow, meaning A[MSB] != B[MSB] and diff[MSB] != A[MSB].
REQ-016 SHALL have port skip_count, output, 3 bits when SKIP_COUNT_EN is defined: number of slices whose borrow bypassed the slice.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE.
REQ-018 SHALL drive in_ready=1 only in IDLE.
REQ-019 On in_valid && in_ready, SHALL register A, B and Bin, clear the slice index k to 0, and move to RUN.
REQ-020 In RUN, each cycle SHALL process slice k (bits k*BLOCK+BLOCK-1 .. k*BLOCK), LSB slice first, using the running borrow.
REQ-021 Per bit, SHALL compute d = a^b^bi and bo = (~a&b) | (~(a^b)&bi).
REQ-022 SHALL treat a slice as propagate when every bit has a == b; the slice borrow-out SHALL then equal the slice borrow-in (bypass mux), otherwise the ripple borrow-out.
REQ-023 After slice WIDTH/BLOCK-1 is processed, SHALL move to DONE with diff, Bout, zero and ovf registered.
REQ-024 Latency: operands accepted at edge T; out_valid SHALL be high in the cycle after edge T+WIDTH/BLOCK (edge T+4 at defaults).
REQ-025 In DONE, SHALL hold out_valid=1 and keep all result outputs stable until out_ready=1; on that edge SHALL return to IDLE with out_valid=0.
REQ-026 SHALL ignore in_valid in RUN and DONE; a new operation cannot start in the same cycle as the out_ready handshake. Throughput: one operation per WIDTH/BLOCK+2 cycles minimum.
REQ-027 Result outputs SHALL keep their last value after the handshake until the next DONE.

Reset
REQ-028 On rst, SHALL enter IDLE immediately, regardless of clk.
REQ-029 On rst, SHALL set in_ready=1, out_valid=0, diff=0, Bout=0, zero=0, ovf=0, skip_count=0, and clear internal operand and borrow registers.
REQ-030 A reset during RUN or DONE SHALL abort the operation; no result is produced.

Configuration
REQ-031 With SKIP_COUNT_EN defined, SHALL provide skip_count, incremented once per bypassed slice in RUN, cleared on acceptance, and valid with out_valid.
REQ-032 Without SKIP_COUNT_EN, the skip_count port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 A=0x00000005, B=0x00000003, Bin=0 -> diff=0x00000002, Bout=0, zero=0, ovf=0, out_valid 4 cycles after acceptance.
REQ-034 A=0x00000000, B=0x00000001, Bin=0 -> diff=0xFFFFFFFF, Bout=1, ovf=0, skip_count=3.
REQ-035 A=B=0x12345678, Bin=1 -> diff=0xFFFFFFFF, Bout=1, skip_count=4; A=B, Bin=0 -> diff=0, zero=1, Bout=0.
REQ-036 A=0x80000000, B=0x00000001, Bin=0 -> diff=0x7FFFFFFF, ovf=1, Bout=0.
REQ-037 out_ready held low for 3 cycles in DONE while in_valid=1 -> outputs stable, in_ready=0, no operand captured; out_ready=1 -> IDLE next cycle.
REQ-038 rst pulsed on the 2nd RUN cycle -> immediately in_ready=1, out_valid=0, diff=0; the next operation completes correctly.
